// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants: register address width, fwd_src encoding, mul/div latencies
package cpu_pkg;
    localparam int REG_AW      = 5;

    localparam int FWD_RF      = 0;
    localparam int FWD_EX      = 1;
    localparam int FWD_MEM     = 2;
    localparam int FWD_WB      = 3;

    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 33;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hazard_md_timer.sv
// rtl/hazard_md_timer.sv - mul/div occupancy countdown; md_busy comes straight from the counter register
module hazard_md_timer
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic de_valid,
    input  logic md_start,
    input  logic md_is_div,
    input  logic stall,
    output logic md_busy
);
    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A start is only taken when DE actually advances; a stalled start retries next cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (de_valid && md_start && !stall) begin
            cnt_d = md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - DE-stage forwarding select, load-use and mul/div interlock
// Optional HAZ_PERF_EN adds perf_lu_cnt / perf_md_cnt stall counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 3,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int SRCW    = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      de_valid,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [REG_AW*NUM_RD-1:0]  rd_addr,
    input  logic                      md_use,
    input  logic                      md_start,
    input  logic                      md_is_div,
    input  logic [NUM_FWD-1:0]        stg_wen,
    input  logic [REG_AW*NUM_FWD-1:0] stg_waddr,
    input  logic [NUM_FWD-1:0]        stg_nrdy,
    output logic [SRCW*NUM_RD-1:0]    fwd_src,
    output logic                      stall,
    output logic                      pc_write,
    output logic                      ir_write,
    output logic                      md_busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]               perf_lu_cnt,
    output logic [31:0]               perf_md_cnt
`endif
);
    logic [NUM_RD-1:0] lu_port;
    logic              load_use;
    logic              md_stall;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        logic [NUM_FWD-1:0] hit;
        logic [SRCW-1:0]    sel;
        logic               sel_nrdy;

        for (genvar gk = 0; gk < NUM_FWD; gk++) begin : g_stg
            assign hit[gk] = rd_en[gi]
                          && (rd_addr[REG_AW*gi +: REG_AW] != '0)
                          && stg_wen[gk]
                          && (stg_waddr[REG_AW*gk +: REG_AW] == rd_addr[REG_AW*gi +: REG_AW]);
        end

        // Scan farthest to nearest so the nearest hit overwrites and wins.
        always_comb begin
            sel      = SRCW'(FWD_RF);
            sel_nrdy = 1'b0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (hit[k]) begin
                    sel      = SRCW'(k + 1);
                    sel_nrdy = stg_nrdy[k];
                end
            end
        end

        assign fwd_src[SRCW*gi +: SRCW] = sel;
        assign lu_port[gi]              = sel_nrdy;
    end

    assign load_use = |lu_port;
    assign md_stall = de_valid & md_use & md_busy;
    assign stall    = de_valid & (load_use | md_stall);
    assign pc_write = ~stall;
    assign ir_write = ~stall;

    hazard_md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .de_valid  (de_valid),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .stall     (stall),
        .md_busy   (md_busy)
    );

`ifdef HAZ_PERF_EN
    logic [31:0] perf_lu_q;
    logic [31:0] perf_md_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu_q <= '0;
            perf_md_q <= '0;
        end else begin
            if (de_valid && load_use) perf_lu_q <= perf_lu_q + 32'd1;
            if (md_stall)             perf_md_q <= perf_md_q + 32'd1;
        end
    end

    assign perf_lu_cnt = perf_lu_q;
    assign perf_md_cnt = perf_md_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int NUM_RD  = 2;
    localparam int NUM_FWD = 3;
    localparam int SRCW    = 2;
    localparam int MUL     = 2;
    localparam int DIV     = 33;

    logic                    clk;
    logic                    reset;
    logic                    de_valid;
    logic [NUM_RD-1:0]       rd_en;
    logic [5*NUM_RD-1:0]     rd_addr;
    logic                    md_use;
    logic                    md_start;
    logic                    md_is_div;
    logic [NUM_FWD-1:0]      stg_wen;
    logic [5*NUM_FWD-1:0]    stg_waddr;
    logic [NUM_FWD-1:0]      stg_nrdy;
    logic [SRCW*NUM_RD-1:0]  fwd_src;
    logic                    stall;
    logic                    pc_write;
    logic                    ir_write;
    logic                    md_busy;
`ifdef HAZ_PERF_EN
    logic [31:0]             perf_lu_cnt;
    logic [31:0]             perf_md_cnt;
`endif

    hazard_ctrl #(
        .NUM_RD  (NUM_RD),
        .NUM_FWD (NUM_FWD),
        .MUL_LAT (MUL),
        .DIV_LAT (DIV),
        .SRCW    (SRCW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .de_valid  (de_valid),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .md_use    (md_use),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .stg_wen   (stg_wen),
        .stg_waddr (stg_waddr),
        .stg_nrdy  (stg_nrdy),
        .fwd_src   (fwd_src),
        .stall     (stall),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .md_busy   (md_busy)
`ifdef HAZ_PERF_EN
        ,
        .perf_lu_cnt (perf_lu_cnt),
        .perf_md_cnt (perf_md_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int n;
    int acc_t;
    int acc_l;
    logic pend;
    int pend_l;
    logic pend_lu;
    logic pend_md;
    logic [31:0] m_lu;
    logic [31:0] m_md;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, n, got, exp);
        end
    endtask

    // Nearest writing stage whose destination equals the (non-zero) source.
    function automatic int exp_fwd(input int i);
        logic [4:0] a;
        a = rd_addr[5*i +: 5];
        if (!rd_en[i] || a == 5'd0) return 0;
        for (int k = 1; k <= NUM_FWD; k++)
            if (stg_wen[k-1] && stg_waddr[5*(k-1) +: 5] == a) return k;
        return 0;
    endfunction

    task automatic model_clear();
        acc_t = -1000;
        acc_l = 0;
        pend  = 1'b0;
        m_lu  = '0;
        m_md  = '0;
    endtask

    task automatic settle_cmp();
        int k;
        logic lu, busy_e, mds, st;
        #3;
        lu = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            k = exp_fwd(i);
            chk($sformatf("fwd_src%0d", i), int'(fwd_src[SRCW*i +: SRCW]), k);
            if (k != 0 && stg_nrdy[k-1]) lu = 1'b1;
        end
        busy_e = (n > acc_t) && (n <= acc_t + acc_l);
        mds    = de_valid & md_use & busy_e;
        st     = de_valid & (lu | mds);
        chk("md_busy", int'(md_busy), int'(busy_e));
        chk("stall", int'(stall), int'(st));
        chk("pc_write", int'(pc_write), int'(!st));
        chk("ir_write", int'(ir_write), int'(!st));
`ifdef HAZ_PERF_EN
        chk("perf_lu_cnt", int'(perf_lu_cnt), int'(m_lu));
        chk("perf_md_cnt", int'(perf_md_cnt), int'(m_md));
`endif
        pend    = de_valid & md_start & ~st;
        pend_l  = md_is_div ? DIV : MUL;
        pend_lu = de_valid & lu;
        pend_md = mds;
    endtask

    task automatic advance();
        @(posedge clk);
        if (pend) begin
            acc_t = n;
            acc_l = pend_l;
        end
        m_lu = m_lu + {31'd0, pend_lu};
        m_md = m_md + {31'd0, pend_md};
        n++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        n++;
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_in();
        de_valid  = 1'b0;
        rd_en     = '0;
        rd_addr   = '0;
        md_use    = 1'b0;
        md_start  = 1'b0;
        md_is_div = 1'b0;
        stg_wen   = '0;
        stg_waddr = '0;
        stg_nrdy  = '0;
    endtask

    task automatic rand_in();
        de_valid = ($urandom % 8) != 0;
        rd_en    = NUM_RD'($urandom);
        for (int i = 0; i < NUM_RD; i++) rd_addr[5*i +: 5] = 5'($urandom % 4);
        stg_wen  = NUM_FWD'($urandom);
        for (int k = 0; k < NUM_FWD; k++) begin
            stg_waddr[5*k +: 5] = 5'($urandom % 4);
            stg_nrdy[k]         = ($urandom % 4) == 0;
        end
        md_start  = ($urandom % 12) == 0;
        md_use    = md_start | (($urandom % 4) == 0);
        md_is_div = ($urandom % 3) == 0;
    endtask

    task automatic md_op(input logic is_div, input int lat);
        clear_in();
        de_valid = 1'b1; md_use = 1'b1; md_start = 1'b1; md_is_div = is_div;
        settle_cmp();
        chk("md_issue_stall", int'(stall), 0);
        advance();
        for (int j = 1; j <= lat + 1; j++) begin
            clear_in();
            de_valid = 1'b1; md_use = 1'b1;
            settle_cmp();
            chk($sformatf("md_busy_lat%0d_j%0d", lat, j), int'(md_busy), int'(j <= lat));
            chk($sformatf("md_stall_lat%0d_j%0d", lat, j), int'(stall), int'(j <= lat));
            advance();
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; n = 0;
        model_clear();
        clear_in();
        reset = 1'b1;
        #2;
        chk("rst_md_busy", int'(md_busy), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_pc_write", int'(pc_write), 1);
        chk("rst_ir_write", int'(ir_write), 1);
        chk("rst_fwd_src", int'(fwd_src), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Forwarding priority.
        clear_in();
        de_valid = 1'b1; rd_en = 2'b01; rd_addr[4:0] = 5'd5;
        stg_wen = 3'b011; stg_waddr[4:0] = 5'd5; stg_waddr[9:5] = 5'd5;
        settle_cmp();
        chk("prio_ex", int'(fwd_src[1:0]), 1);
        advance();
        stg_wen = 3'b010;
        settle_cmp();
        chk("prio_mem", int'(fwd_src[1:0]), 2);
        advance();
        clear_in();
        de_valid = 1'b1; rd_en = 2'b01; stg_wen = 3'b001;
        settle_cmp();
        chk("zero_reg", int'(fwd_src[1:0]), 0);
        advance();

        // Load-use then release once the load sits in MEM with data.
        clear_in();
        de_valid = 1'b1; rd_en = 2'b10; rd_addr[9:5] = 5'd8;
        stg_wen = 3'b001; stg_waddr[4:0] = 5'd8; stg_nrdy = 3'b001;
        settle_cmp();
        chk("lu_stall", int'(stall), 1);
        chk("lu_pc_write", int'(pc_write), 0);
        advance();
        stg_wen = 3'b010; stg_waddr = '0; stg_waddr[9:5] = 5'd8; stg_nrdy = 3'b000;
        settle_cmp();
        chk("lu_release", int'(stall), 0);
        chk("lu_fwd_mem", int'(fwd_src[3:2]), 2);
        advance();

        // Shadowed load.
        clear_in();
        de_valid = 1'b1; rd_en = 2'b01; rd_addr[4:0] = 5'd9;
        stg_wen = 3'b011; stg_waddr[4:0] = 5'd9; stg_waddr[9:5] = 5'd9; stg_nrdy = 3'b010;
        settle_cmp();
        chk("shadow_fwd", int'(fwd_src[1:0]), 1);
        chk("shadow_stall", int'(stall), 0);
        advance();

        // Not valid: no stall, forwarding still decodes.
        de_valid = 1'b0; stg_nrdy = 3'b001;
        settle_cmp();
        chk("inv_stall", int'(stall), 0);
        chk("inv_fwd", int'(fwd_src[1:0]), 1);
        advance();

        md_op(1'b1, DIV);
        md_op(1'b0, MUL);

        // Asynchronous reset in the middle of a divide.
        clear_in();
        de_valid = 1'b1; md_use = 1'b1; md_start = 1'b1; md_is_div = 1'b1;
        settle_cmp();
        advance();
        for (int j = 0; j < 16; j++) begin
            clear_in();
            de_valid = 1'b1; md_use = 1'b1;
            settle_cmp();
            advance();
        end
        clear_in();
        de_valid = 1'b1; md_use = 1'b1;
        #1;
        chk("pre_rst_busy", int'(md_busy), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", int'(md_busy), 0);
        chk("async_rst_stall", int'(stall), 0);
        model_clear();
        @(posedge clk);
        n++;
        #1;
        reset = 1'b0;
        md_start = 1'b1; md_is_div = 1'b1;
        settle_cmp();
        chk("post_rst_accept", int'(stall), 0);
        advance();
        clear_in();
        de_valid = 1'b1; md_use = 1'b1;
        settle_cmp();
        chk("post_rst_busy", int'(md_busy), 1);
        advance();

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rand_in();
            if (($urandom % 700) == 0) begin
                do_reset();
            end else begin
                settle_cmp();
                advance();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
